stripe_lane_scheduler: RTL and testbench

- Controller in phy_tx placed upstream of the two-lane striping datapath.
- Buffers incoming 32-bit words in a small FIFO and dispatches them to lane 0 and lane 1 in strict alternation, with per-lane valid/ready backpressure.
- On end-of-packet flush, pads an odd word count with one IDLE_WORD on lane 1, so every packet occupies an even number of lane slots for receiver deskew.

---
 rtl/stripe_lane_scheduler.sv | 152 +++++++++++++++
 tb/tb_stripe_lane_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stripe_lane_scheduler.sv
// rtl/stripe_lane_scheduler.sv - FIFO-buffered two-lane alternating dispatcher with odd-packet padding
module stripe_lane_scheduler #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] IDLE_WORD = 32'hBCBCBCBC
) (
    input  logic                     clk_2f,
    input  logic                     reset,
    input  logic [31:0]              data_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic                     flush,
    output logic [31:0]              lane_0,
    output logic                     valid_0,
    input  logic                     ready_0,
    output logic [31:0]              lane_1,
    output logic                     valid_1,
    input  logic                     ready_1,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE0, SEND0, IDLE1, SEND1} state_t;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_flush_pending;
    logic          r_drop_err;
    logic [31:0]   r_lane_0;
    logic [31:0]   r_lane_1;
    logic          r_valid_0;
    logic          r_valid_1;
    state_t        r_state;

    logic          w_empty;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head;

    assign w_empty = (r_count == '0);
    assign w_ready = (r_count < L_DEPTH) && !r_flush_pending;
    assign w_push  = valid_in && w_ready;
    assign w_head  = r_mem[r_rd_ptr];

    // Every state that can load a lane pops whenever data is waiting.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE0) || (r_state == IDLE1) ||
                    ((r_state == SEND0) && ready_0) ||
                    ((r_state == SEND1) && ready_1));

    assign ready_out  = w_ready;
    assign lane_0     = r_lane_0;
    assign lane_1     = r_lane_1;
    assign valid_0    = r_valid_0;
    assign valid_1    = r_valid_1;
    assign fifo_count = r_count;
    assign drop_err   = r_drop_err;

    always_ff @(posedge clk_2f) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_flush_pending <= 1'b0;
            r_drop_err      <= 1'b0;
            r_lane_0        <= '0;
            r_lane_1        <= '0;
            r_valid_0       <= 1'b0;
            r_valid_1       <= 1'b0;
            r_state         <= IDLE0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (valid_in && !w_ready) begin
                r_drop_err <= 1'b1;
            end
            // A clear by the FSM below overrides a redundant flush pulse.
            if (flush) begin
                r_flush_pending <= 1'b1;
            end

            case (r_state)
                IDLE0: begin
                    if (!w_empty) begin
                        r_lane_0  <= w_head;
                        r_valid_0 <= 1'b1;
                        r_state   <= SEND0;
                    end else if (r_flush_pending) begin
                        r_flush_pending <= 1'b0;
                    end
                end
                SEND0: begin
                    if (ready_0) begin
                        r_lane_0  <= '0;
                        r_valid_0 <= 1'b0;
                        if (!w_empty) begin
                            r_lane_1  <= w_head;
                            r_valid_1 <= 1'b1;
                            r_state   <= SEND1;
                        end else begin
                            r_state <= IDLE1;
                        end
                    end
                end
                IDLE1: begin
                    if (!w_empty) begin
                        r_lane_1  <= w_head;
                        r_valid_1 <= 1'b1;
                        r_state   <= SEND1;
                    end else if (r_flush_pending) begin
                        r_lane_1        <= IDLE_WORD;
                        r_valid_1       <= 1'b1;
                        r_flush_pending <= 1'b0;
                        r_state         <= SEND1;
                    end
                end
                SEND1: begin
                    if (ready_1) begin
                        r_lane_1  <= '0;
                        r_valid_1 <= 1'b0;
                        if (!w_empty) begin
                            r_lane_0  <= w_head;
                            r_valid_0 <= 1'b1;
                            r_state   <= SEND0;
                        end else begin
                            r_state <= IDLE0;
                        end
                    end
                end
                default: r_state <= IDLE0;
            endcase
        end
    end

endmodule

// File: tb/tb_stripe_lane_scheduler.sv
// tb/tb_stripe_lane_scheduler.sv - table, directed and random checks for stripe_lane_scheduler
module tb_stripe_lane_scheduler;

    localparam int          DEPTH = 4;
    localparam logic [31:0] IDLE  = 32'hBCBCBCBC;

    typedef logic [69:0] w_t;

    typedef struct {
        logic        vi;
        logic [31:0] di;
        logic        fl;
        logic        v0;
        logic [31:0] l0;
        logic        v1;
        logic [31:0] l1;
        logic [2:0]  cnt;
        logic        rdy;
    } vec_t;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic        flush;
    logic [31:0] lane_0;
    logic        valid_0;
    logic        ready_0;
    logic [31:0] lane_1;
    logic        valid_1;
    logic        ready_1;
    logic [2:0]  fifo_count;
    logic        drop_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          cnt_m;
    int          pkt_words;
    int          next_lane;
    logic        pend_push;
    logic        pend_drop;
    logic        drop_m;
    logic        prev_v0;
    logic        prev_v1;

    vec_t tbl[19];

    always #5 clk_2f = ~clk_2f;

    stripe_lane_scheduler #(.DEPTH(DEPTH), .IDLE_WORD(IDLE)) dut (
        .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .flush(flush), .lane_0(lane_0), .valid_0(valid_0),
        .ready_0(ready_0), .lane_1(lane_1), .valid_1(valid_1), .ready_1(ready_1),
        .fifo_count(fifo_count), .drop_err(drop_err)
    );

    task automatic chk(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_2f);
        #1;
    endtask

    function automatic vec_t mk(input logic vi, input logic [31:0] di, input logic fl,
                                input logic v0, input logic [31:0] l0, input logic v1,
                                input logic [31:0] l1, input logic [2:0] cnt, input logic rdy);
        vec_t v;
        v.vi = vi; v.di = di; v.fl = fl; v.v0 = v0; v.l0 = l0;
        v.v1 = v1; v.l1 = l1; v.cnt = cnt; v.rdy = rdy;
        return v;
    endfunction

    task automatic drain(input string name, input int lim);
        int n = 0;
        valid_in = 1'b0;
        flush    = 1'b0;
        ready_0  = 1'b1;
        ready_1  = 1'b1;
        while (exp_q.size() != 0 && n < lim) begin
            cyc();
            n++;
        end
        chk(name, w_t'(exp_q.size()), w_t'(0));
        repeat (2) cyc();
    endtask

    // Scoreboard: words accepted upstream (plus a pad after each odd-length packet)
    // must leave on alternating lanes in order; occupancy = accepted - loaded.
    always @(negedge clk_2f) begin
        if (reset) begin
            exp_q.delete();
            cnt_m = 0; pkt_words = 0; next_lane = 0;
            pend_push = 1'b0; pend_drop = 1'b0; drop_m = 1'b0;
            prev_v0 = 1'b0; prev_v1 = 1'b0;
        end else begin
            if (pend_push) cnt_m++;
            drop_m = drop_m | pend_drop;
            if (valid_0 && !prev_v0 && lane_0 != IDLE) cnt_m--;
            if (valid_1 && !prev_v1 && lane_1 != IDLE) cnt_m--;
            prev_v0 = valid_0;
            prev_v1 = valid_1;
            chk("fifo_count", w_t'(fifo_count), w_t'(cnt_m));
            chk("drop_err", w_t'(drop_err), w_t'(drop_m));
            chk("one_lane_valid", w_t'(valid_0 & valid_1), w_t'(0));
            chk("full_guard", w_t'((cnt_m >= DEPTH) && ready_out), w_t'(0));
            if (valid_0 && ready_0) begin
                chk("lane0_order", w_t'(next_lane), w_t'(0));
                if (exp_q.size() == 0) chk("lane0_extra_word", w_t'(lane_0), w_t'(0));
                else chk("lane0_data", w_t'(lane_0), w_t'(exp_q.pop_front()));
                next_lane = 1;
            end
            if (valid_1 && ready_1) begin
                chk("lane1_order", w_t'(next_lane), w_t'(1));
                if (exp_q.size() == 0) chk("lane1_extra_word", w_t'(lane_1), w_t'(0));
                else chk("lane1_data", w_t'(lane_1), w_t'(exp_q.pop_front()));
                next_lane = 0;
            end
            pend_push = valid_in && ready_out;
            pend_drop = valid_in && !ready_out;
            if (pend_push) begin
                exp_q.push_back(data_in);
                pkt_words++;
            end
            if (flush) begin
                if (pkt_words % 2 == 1) exp_q.push_back(IDLE);
                pkt_words = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;

        tbl[0]  = mk(1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd1, 1'b1);
        tbl[1]  = mk(1'b1, 32'h22222222, 1'b0, 1'b1, 32'h11111111, 1'b0, 32'h0, 3'd1, 1'b1);
        tbl[2]  = mk(1'b1, 32'h33333333, 1'b0, 1'b0, 32'h0, 1'b1, 32'h22222222, 3'd1, 1'b1);
        tbl[3]  = mk(1'b1, 32'h44444444, 1'b0, 1'b1, 32'h33333333, 1'b0, 32'h0, 3'd1, 1'b1);
        tbl[4]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44444444, 3'd0, 1'b1);
        tbl[5]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b1);
        tbl[6]  = mk(1'b1, 32'h0A0A0A0A, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd1, 1'b1);
        tbl[7]  = mk(1'b1, 32'h0B0B0B0B, 1'b0, 1'b1, 32'h0A0A0A0A, 1'b0, 32'h0, 3'd1, 1'b1);
        tbl[8]  = mk(1'b1, 32'h0C0C0C0C, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0B0B0B0B, 3'd1, 1'b1);
        tbl[9]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h0C0C0C0C, 1'b0, 32'h0, 3'd0, 1'b0);
        tbl[10] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b0);
        tbl[11] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, IDLE, 3'd0, 1'b1);
        tbl[12] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b1);
        tbl[13] = mk(1'b1, 32'h0D0D0D0D, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd1, 1'b1);
        tbl[14] = mk(1'b1, 32'h0E0E0E0E, 1'b0, 1'b1, 32'h0D0D0D0D, 1'b0, 32'h0, 3'd1, 1'b1);
        tbl[15] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0E0E0E0E, 3'd0, 1'b0);
        tbl[16] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b0);
        tbl[17] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b1);
        tbl[18] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b1);

        reset = 1'b1; data_in = '0; valid_in = 1'b0; flush = 1'b0;
        ready_0 = 1'b1; ready_1 = 1'b1;
        cyc(); cyc();
        chk("reset_state", w_t'({valid_0, lane_0, valid_1, lane_1, fifo_count, ready_out}),
            w_t'({1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b1}));
        chk("reset_drop_err", w_t'(drop_err), w_t'(0));
        reset = 1'b0;

        // Alternation, odd-packet pad, even packet without pad
        for (int i = 0; i < 19; i++) begin
            valid_in = tbl[i].vi; data_in = tbl[i].di; flush = tbl[i].fl;
            cyc();
            chk($sformatf("row%0d", i),
                w_t'({valid_0, lane_0, valid_1, lane_1, fifo_count, ready_out}),
                w_t'({tbl[i].v0, tbl[i].l0, tbl[i].v1, tbl[i].l1, tbl[i].cnt, tbl[i].rdy}));
        end
        valid_in = 1'b0; flush = 1'b0;

        // Lane 0 stalled while six words are offered; the sixth overflows
        ready_0 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            valid_in = 1'b1; data_in = 32'h00B00000 + 32'(k);
            cyc();
            if (k == 4) chk("stall_full", w_t'({valid_0, lane_0, fifo_count, ready_out, drop_err}),
                            w_t'({1'b1, 32'h00B00000, 3'd4, 1'b0, 1'b0}));
        end
        chk("stall_drop", w_t'({valid_0, lane_0, fifo_count, ready_out, drop_err}),
            w_t'({1'b1, 32'h00B00000, 3'd4, 1'b0, 1'b1}));
        drain("stall_drain", 40);
        chk("drop_sticky", w_t'({drop_err, fifo_count}), w_t'({1'b1, 3'd0}));

        // Reset while lane 1 is stalled with three words buffered
        reset = 1'b1; cyc(); reset = 1'b0;
        ready_0 = 1'b1; ready_1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            valid_in = 1'b1; data_in = 32'h00E00000 + 32'(k);
            cyc();
        end
        valid_in = 1'b0;
        chk("send1_loaded", w_t'({valid_0, valid_1, lane_1, fifo_count}),
            w_t'({1'b0, 1'b1, 32'h00E00001, 3'd3}));
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("midreset_state", w_t'({valid_0, lane_0, valid_1, lane_1, fifo_count, ready_out, drop_err}),
            w_t'({1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0}));
        ready_1 = 1'b1;
        valid_in = 1'b1; data_in = 32'h00F00000;
        cyc();
        valid_in = 1'b0;
        cyc();
        chk("midreset_idle0", w_t'({valid_0, lane_0, valid_1}), w_t'({1'b1, 32'h00F00000, 1'b0}));
        drain("midreset_drain", 20);

        // Simultaneous push and pop at count 2, then wrap the pointers
        reset = 1'b1; cyc(); reset = 1'b0;
        ready_0 = 1'b0; ready_1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid_in = 1'b1; data_in = 32'h00D00000 + 32'(k);
            cyc();
        end
        chk("pushpop_pre", w_t'(fifo_count), w_t'(2));
        ready_0 = 1'b1; data_in = 32'h00D00003;
        cyc();
        chk("pushpop_same", w_t'({fifo_count, valid_1, lane_1}), w_t'({3'd2, 1'b1, 32'h00D00001}));
        for (int k = 4; k < 10; k++) begin
            data_in = 32'h00D00000 + 32'(k);
            cyc();
        end
        drain("wrap_drain", 40);

        // Randomised traffic against the scoreboard
        reset = 1'b1; cyc(); reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            ready_0  = ($urandom_range(0, 3) != 0);
            ready_1  = ($urandom_range(0, 3) != 0);
            d        = $urandom & 32'h7FFFFFFF;
            data_in  = d;
            valid_in = ($urandom_range(0, 2) != 0) && ready_out;
            flush    = ($urandom_range(0, 15) == 0) && ready_out;
            cyc();
        end
        drain("random_drain", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
